// File: rtl/controlador_sinal_pkg.sv
// Shared definitions for the output-side signal controller: state encoding and the
// default burst timing shared with the button front end.
package controlador_sinal_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ON   = 2'd1;
   localparam logic [1:0] GAP  = 2'd2;

   typedef enum logic [1:0] {
      StIdle = IDLE,
      StOn   = ON,
      StGap  = GAP
   } estado_e;

   localparam int unsigned OnCyclesDef  = 16;
   localparam int unsigned OffCyclesDef = 16;
   localparam int unsigned MaxPendDef   = 7;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/controlador_sinal.sv
// Turns one-cycle event pulses into active-low bursts (ON low, then OFF high gap),
// queueing events that arrive mid-burst in a saturating pending counter.
module controlador_sinal
   import controlador_sinal_pkg::*;
#(
   parameter int unsigned ON_CYCLES  = OnCyclesDef,
   parameter int unsigned OFF_CYCLES = OffCyclesDef,
   parameter int unsigned MAX_PEND   = MaxPendDef
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pulso_in,
   output logic sinal_out,
   output logic ocupado
);

   localparam int unsigned CntW  = max_u(1, $clog2(max_u(ON_CYCLES, OFF_CYCLES)));
   localparam int unsigned PendW = max_u(1, $clog2(MAX_PEND + 1));

   localparam logic [CntW-1:0]  OnLast  = CntW'(ON_CYCLES - 1);
   localparam logic [CntW-1:0]  OffLast = CntW'(OFF_CYCLES - 1);
   localparam logic [PendW-1:0] PendMax = PendW'(MAX_PEND);

   estado_e          estado_q, estado_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [PendW-1:0] pend_q, pend_d;
   logic             sinal_d, ocupado_d;

   always_comb begin
      estado_d = estado_q;
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      case (estado_q)
         StIdle: begin
            if (pulso_in) begin
               estado_d = StOn;
               cnt_d    = '0;
            end
         end
         StOn: begin
            if (pulso_in && pend_q != PendMax) pend_d = pend_q + 1'b1;
            if (cnt_q == OnLast) begin
               estado_d = StGap;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StGap: begin
            if (cnt_q == OffLast) begin
               cnt_d = '0;
               // A pulse on the last gap cycle cancels the dequeue, even when saturated.
               if (pend_q != '0) begin
                  estado_d = StOn;
                  pend_d   = pulso_in ? pend_q : pend_q - 1'b1;
               end else if (pulso_in) begin
                  estado_d = StOn;
               end else begin
                  estado_d = StIdle;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (pulso_in && pend_q != PendMax) pend_d = pend_q + 1'b1;
            end
         end
         default: begin
            estado_d = StIdle;
            cnt_d    = '0;
         end
      endcase
      sinal_d   = (estado_d != StOn);
      ocupado_d = (estado_d != StIdle) || (pend_d != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q  <= StIdle;
         cnt_q     <= '0;
         pend_q    <= '0;
         sinal_out <= 1'b1;
         ocupado   <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         sinal_out <= sinal_d;
         ocupado   <= ocupado_d;
      end
   end

endmodule

// File: tb/tb_controlador_sinal.sv
// Scoreboard bench for controlador_sinal: a burst-scheduling model predicts burst start
// cycles and the per-cycle output waveform.
module tb_controlador_sinal;

   localparam int unsigned OnC  = 4;
   localparam int unsigned OffC = 3;
   localparam int unsigned MaxP = 2;
   localparam int          Per  = OnC + OffC;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pulso_in = 1'b0;
   logic sinal_out, ocupado;

   controlador_sinal #(
      .ON_CYCLES (OnC),
      .OFF_CYCLES(OffC),
      .MAX_PEND  (MaxP)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pulso_in (pulso_in),
      .sinal_out(sinal_out),
      .ocupado  (ocupado)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int starts[$];   // every burst start cycle the model has scheduled
   int exp_q[$];    // burst starts not yet observed on sinal_out
   int checks = 0;
   int errors = 0;
   bit done = 1'b0;
   bit prev_sinal = 1'b1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, req);
      end
   endtask

   function automatic bit exp_low(input int c);
      for (int i = 0; i < starts.size(); i++)
         if (c >= starts[i] && c < starts[i] + OnC) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit exp_busy(input int c);
      for (int i = 0; i < starts.size(); i++)
         if (c >= starts[i] && c < starts[i] + Per) return 1'b1;
      return 1'b0;
   endfunction

   // Event held high during cycle c. Bursts occupy [s, s+Per); an idle block starts at c+1,
   // otherwise the event is appended back-to-back unless MaxP bursts already wait beyond c+1.
   function automatic void model_event(input int c);
      int n;
      int ns;
      if (starts.size() == 0 || c >= starts[$] + Per) begin
         starts.push_back(c + 1);
         exp_q.push_back(c + 1);
      end else begin
         n = 0;
         for (int i = 0; i < starts.size(); i++)
            if (starts[i] > c + 1) n++;
         if (n < MaxP) begin
            ns = starts[$] + Per;
            starts.push_back(ns);
            exp_q.push_back(ns);
         end
      end
   endfunction

   always @(negedge clk) begin
      if (!done) begin
         if (!rst_n) begin
            check("rst_sinal", sinal_out, 1);
            check("rst_ocupado", ocupado, 0);
         end else begin
            check("sinal", sinal_out, exp_low(cyc) ? 0 : 1);
            check("ocupado", ocupado, exp_busy(cyc) ? 1 : 0);
            if (prev_sinal && !sinal_out) begin
               if (exp_q.size() == 0) check("unexpected_burst", cyc, -1);
               else check("burst_start", cyc, exp_q.pop_front());
            end
         end
         prev_sinal <= sinal_out;
      end
   end

   task automatic step(input bit p);
      @(posedge clk);
      #1;
      pulso_in = p;
      if (p) model_event(cyc);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      pulso_in = 1'b0;
      rst_n = 1'b0;
      #1;
      check("async_rst_sinal", sinal_out, 1);
      check("async_rst_ocupado", ocupado, 0);
      starts.delete();
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(4);
      // single event
      step(1'b1); idle(15);
      // queueing at relative cycles 0, 2, 3
      step(1'b1); step(1'b0); step(1'b1); step(1'b1); idle(25);
      // saturation: six consecutive events
      repeat (6) step(1'b1);
      idle(25);
      // event on the last gap cycle with nothing pending
      step(1'b1); idle(6); step(1'b1); idle(15);
      // event on the last gap cycle with one pending
      step(1'b1); step(1'b1); idle(5); step(1'b1); idle(25);
      // event on the last gap cycle with the queue saturated
      step(1'b1); step(1'b1); step(1'b1); idle(4); step(1'b1); idle(35);
      // reset mid-burst, then a fresh single event
      step(1'b1); step(1'b1); do_reset(); idle(5); step(1'b1); idle(15);
      // random traffic with a reset in the middle
      for (int i = 0; i < 300; i++) step($urandom_range(0, 3) == 0);
      do_reset();
      for (int i = 0; i < 300; i++) step($urandom_range(0, 2) == 0);
      idle(40);
      done = 1'b1;
      check("bursts_outstanding", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
